// File: rtl/tdm_demux_1x4_rx.sv
// ----------------------------------------------------------------------------
// tdm_demux_1x4_rx
//   Time-division 1-to-4 demultiplexer, the receive side of a round-robin
//   4-to-1 mux link. Beats arrive in select order 0,1,2,3. The beat that
//   carries channel 0 is marked by sync. Each complete frame is rebuilt into
//   a 4-channel vector. Channel i lands at y_out[i*DW +: DW].
//
// Parameters
//   DW        width of one channel word
//   CW        width of the completed-frame counter
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   d_in        serial channel word
//   in_valid    d_in / sync qualify this cycle
//   sync        beat carries channel 0 (frame start)
//   y_out       last complete frame
//   frame_valid one-cycle pulse: y_out just updated
//   frame_err   one-cycle pulse: framing error detected
//   sel         channel index expected for the next accepted beat
//   frame_cnt   completed frames, wraps modulo 2^CW
// ----------------------------------------------------------------------------

// One staging slot. A clear discards a partially received word. The FSM
// never asserts clr and ld for the same slot in the same cycle, but clr
// still takes priority so the slot is safe even if that changes.
module tdm_demux_slot #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic          clr,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (ld)  q <= d;
    end
endmodule

module tdm_demux_1x4_rx #(
    parameter int DW = 1,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   d_in,
    input  logic            in_valid,
    input  logic            sync,
    output logic [4*DW-1:0] y_out,
    output logic            frame_valid,
    output logic            frame_err,
    output logic [1:0]      sel,
    output logic [CW-1:0]   frame_cnt
);
    localparam int NUM_SLOTS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                         state;
    logic [NUM_SLOTS-1:0]           slot_ld;
    logic [NUM_SLOTS-1:0]           slot_clr;
    logic [NUM_SLOTS-1:0][DW-1:0]   slot_q;

    // Slots 0..2 are staged. Channel 3 never needs a slot because the
    // closing beat goes straight into the top of y_out.
    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
            tdm_demux_slot #(.DW(DW)) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .ld    (slot_ld[i]),
                .clr   (slot_clr[i]),
                .d     (d_in),
                .q     (slot_q[i])
            );
        end
    endgenerate

    // Slot load/clear decode. This must mirror the FSM branches below.
    always_comb begin
        slot_ld  = '0;
        slot_clr = '0;
        if (in_valid) begin
            if (state == IDLE) begin
                if (sync) slot_ld[0] = 1'b1;
            end else if (sync) begin
                slot_ld[0] = 1'b1;
                // A sync that arrives mid-frame abandons the partial frame.
                if (sel != 2'd0) slot_clr = 3'b110;
            end else begin
                case (sel)
                    2'd1:    slot_ld[1] = 1'b1;
                    2'd2:    slot_ld[2] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= 2'd0;
            y_out       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        // Non-sync beats are dropped silently while hunting.
                        if (sync) begin
                            sel   <= 2'd1;
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (sync) begin
                            if (sel != 2'd0) frame_err <= 1'b1;
                            sel <= 2'd1;
                        end else if (sel == 2'd0) begin
                            // A frame boundary without sync means alignment
                            // was lost, so go back to hunting for sync.
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else if (sel == 2'd3) begin
                            y_out       <= {d_in, slot_q};
                            frame_valid <= 1'b1;
                            frame_cnt   <= frame_cnt + CW'(1);
                            sel         <= 2'd0;
                        end else begin
                            sel <= sel + 2'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_1x4_rx.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux_1x4_rx
//   Directed bench for tdm_demux_1x4_rx. The DUT uses DW=1 and CW=2, so the
//   counter wrap can be reached in a few frames. Inputs change after the
//   negative edge. Outputs are sampled 1ns after the rising edge that
//   consumed the beat.
// ----------------------------------------------------------------------------
module tb_tdm_demux_1x4_rx;
    localparam int DW = 1;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   d_in = '0;
    logic            in_valid = 1'b0;
    logic            sync = 1'b0;
    logic [4*DW-1:0] y_out;
    logic            frame_valid;
    logic            frame_err;
    logic [1:0]      sel;
    logic [CW-1:0]   frame_cnt;

    int checks = 0;
    int errors = 0;

    tdm_demux_1x4_rx #(.DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_in        (d_in),
        .in_valid    (in_valid),
        .sync        (sync),
        .y_out       (y_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .sel         (sel),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    // Present one cycle of input, then return just after the consuming edge.
    task automatic step(input logic v, input logic s, input logic d);
        @(negedge clk);
        in_valid = v;
        sync     = s;
        d_in     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({y_out, sel, frame_cnt, frame_valid, frame_err} !== '0) begin
            $display("FAIL reset_held: got y=%b sel=%0d cnt=%0d fv=%b fe=%b, want all 0",
                     y_out, sel, frame_cnt, frame_valid, frame_err);
            errors++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({y_out, sel, frame_cnt, frame_valid, frame_err} !== '0) begin
            $display("FAIL reset_release: got y=%b sel=%0d cnt=%0d fv=%b fe=%b, want all 0",
                     y_out, sel, frame_cnt, frame_valid, frame_err);
            errors++;
        end
    endtask

    task automatic test_basic_frame();
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (sel !== 2'd1) begin
            $display("FAIL basic_sel1: got %0d want 1", sel); errors++;
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (y_out !== 4'b0000 || frame_valid !== 1'b0) begin
            $display("FAIL basic_early: got y=%b fv=%b want 0000/0", y_out, frame_valid); errors++;
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (y_out !== 4'b0001 || frame_valid !== 1'b1 || frame_cnt !== 2'd1 || sel !== 2'd0) begin
            $display("FAIL basic_done: got y=%b fv=%b cnt=%0d sel=%0d want 0001/1/1/0",
                     y_out, frame_valid, frame_cnt, sel);
            errors++;
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (frame_valid !== 1'b0 || y_out !== 4'b0001) begin
            $display("FAIL basic_pulse: got fv=%b y=%b want 0/0001", frame_valid, y_out); errors++;
        end
    endtask

    task automatic test_gaps();
        // Frame a = {1,1,1,0}. Gap cycles carry sync=1 with in_valid=0,
        // and those cycles must be ignored.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (sel !== 2'd2 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            $display("FAIL gap_hold: got sel=%0d fv=%b fe=%b want 2/0/0", sel, frame_valid, frame_err);
            errors++;
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (y_out !== 4'b0111 || frame_valid !== 1'b1 || frame_cnt !== 2'd2) begin
            $display("FAIL gap_frame1: got y=%b fv=%b cnt=%0d want 0111/1/2", y_out, frame_valid, frame_cnt);
            errors++;
        end
        // Frame a = {0,1,1,1}, sent back to back after the previous frame.
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (frame_valid !== 1'b0 || sel !== 2'd1) begin
            $display("FAIL gap_b2b: got fv=%b sel=%0d want 0/1", frame_valid, sel); errors++;
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (y_out !== 4'b1110 || frame_valid !== 1'b1 || frame_cnt !== 2'd3) begin
            $display("FAIL gap_frame2: got y=%b fv=%b cnt=%0d want 1110/1/3", y_out, frame_valid, frame_cnt);
            errors++;
        end
    endtask

    task automatic test_mid_sync();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || sel !== 2'd1 || y_out !== 4'b1110 || frame_cnt !== 2'd3) begin
            $display("FAIL midsync_err: got fe=%b sel=%0d y=%b cnt=%0d want 1/1/1110/3",
                     frame_err, sel, y_out, frame_cnt);
            errors++;
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (frame_err !== 1'b0) begin
            $display("FAIL midsync_pulse: got fe=%b want 0", frame_err); errors++;
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        // This frame also wraps the 2-bit counter from 3 to 0.
        checks++;
        if (y_out !== 4'b0010 || frame_valid !== 1'b1 || frame_cnt !== 2'd0) begin
            $display("FAIL midsync_frame: got y=%b fv=%b cnt=%0d want 0010/1/0", y_out, frame_valid, frame_cnt);
            errors++;
        end
    endtask

    task automatic test_missing_sync();
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (frame_err !== 1'b1 || sel !== 2'd0 || y_out !== 4'b0010 || frame_cnt !== 2'd0) begin
            $display("FAIL nosync_err: got fe=%b sel=%0d y=%b cnt=%0d want 1/0/0010/0",
                     frame_err, sel, y_out, frame_cnt);
            errors++;
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (frame_err !== 1'b0 || sel !== 2'd0) begin
            $display("FAIL nosync_idle: got fe=%b sel=%0d want 0/0", frame_err, sel); errors++;
        end
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (sel !== 2'd1 || frame_err !== 1'b0) begin
            $display("FAIL nosync_restart: got sel=%0d fe=%b want 1/0", sel, frame_err); errors++;
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (y_out !== 4'b1001 || frame_valid !== 1'b1 || frame_cnt !== 2'd1) begin
            $display("FAIL nosync_frame: got y=%b fv=%b cnt=%0d want 1001/1/1", y_out, frame_valid, frame_cnt);
            errors++;
        end
    endtask

    // Five frames back to back. Channel values come from a table, and the
    // counter is expected to follow 2,3,0,1,2 from its current value of 1.
    task automatic test_back_to_back();
        logic [3:0] frames [5];
        logic [3:0] f;
        logic [1:0] exp_cnt;
        frames[0] = 4'b1010; frames[1] = 4'b0101; frames[2] = 4'b1100;
        frames[3] = 4'b0011; frames[4] = 4'b1111;
        exp_cnt = 2'd1;
        for (int k = 0; k < 5; k++) begin
            f = frames[k];
            for (int b = 0; b < 4; b++) step(1'b1, b == 0, f[b]);
            exp_cnt = exp_cnt + 2'd1;
            checks++;
            if (y_out !== f || frame_valid !== 1'b1 || frame_cnt !== exp_cnt) begin
                $display("FAIL b2b_frame%0d: got y=%b fv=%b cnt=%0d want %b/1/%0d",
                         k, y_out, frame_valid, frame_cnt, f, exp_cnt);
                errors++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        // Assert reset between edges. The outputs must clear without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({y_out, sel, frame_cnt, frame_valid, frame_err} !== '0) begin
            $display("FAIL rst_async: got y=%b sel=%0d cnt=%0d fv=%b fe=%b want all 0",
                     y_out, sel, frame_cnt, frame_valid, frame_err);
            errors++;
        end
        @(negedge clk);
        in_valid = 1'b1; sync = 1'b0; d_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        // The remaining beats of the discarded frame must not complete it.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0 || sel !== 2'd0 || y_out !== 4'b0000
            || frame_cnt !== 2'd0) begin
            $display("FAIL rst_midframe: got fv=%b fe=%b sel=%0d y=%b cnt=%0d want 0/0/0/0000/0",
                     frame_valid, frame_err, sel, y_out, frame_cnt);
            errors++;
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gaps();
        test_mid_sync();
        test_missing_sync();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
